// File: rtl/debug_controller.sv
// Byte-serial debug controller: loads instruction memory from an rx byte stream,
// gates the datapath for run/step, then streams a frozen snapshot out MSB byte first.
module debug_controller #(
  parameter int INSTRUCTION_BITS = 32,
  parameter int PC_BITS          = 11,
  parameter int DUMP_BITS        = 512,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_WORD = 32'hFC000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_valid,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_valid,
  input  logic                        i_tx_ready,
  output logic                        o_enable,
  output logic                        o_write_inst_mem,
  output logic [PC_BITS-1:0]          o_inst_mem_addr,
  output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
  input  logic                        i_halt,
  input  logic [DUMP_BITS-1:0]        i_snapshot,
  output logic                        o_busy,
  output logic [2:0]                  dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_LOAD_WR = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_STEP    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_SEND    = 3'd6;

  localparam int IN_BYTES = INSTRUCTION_BITS / 8;
  localparam int TX_BYTES = DUMP_BITS / 8;
  localparam int BCW      = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam int TXW      = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;

  localparam logic [BCW-1:0]     LAST_IN  = BCW'(IN_BYTES - 1);
  localparam logic [TXW-1:0]     LAST_TX  = TXW'(TX_BYTES - 1);
  localparam logic [PC_BITS-1:0] ADDR_MAX = {PC_BITS{1'b1}};

  // Handshake: a tx byte transfers on a rising edge where o_tx_valid and
  // i_tx_ready are both high; o_tx_valid/o_tx_data hold until that happens.

  logic [2:0]                  state;
  logic [PC_BITS-1:0]          addr;
  logic [BCW-1:0]              byte_cnt;
  logic [INSTRUCTION_BITS-1:0] word;
  logic [INSTRUCTION_BITS-1:0] word_next;
  logic [DUMP_BITS-1:0]        dump;
  logic [TXW-1:0]              tx_idx;

  assign word_next = (word << 8) | INSTRUCTION_BITS'(i_rx_data);
  assign o_busy    = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      addr             <= '0;
      byte_cnt         <= '0;
      word             <= '0;
      dump             <= '0;
      tx_idx           <= '0;
      o_enable         <= 1'b0;
      o_write_inst_mem <= 1'b0;
      o_inst_mem_addr  <= '0;
      o_inst_mem_data  <= '0;
      o_tx_valid       <= 1'b0;
      o_tx_data        <= '0;
    end else begin
      o_write_inst_mem <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              8'h01: begin
                state    <= S_LOAD;
                addr     <= '0;
                byte_cnt <= '0;
              end
              8'h02: begin
                state    <= S_RUN;
                o_enable <= 1'b1;
              end
              8'h03: begin
                state    <= S_STEP;
                o_enable <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (i_rx_valid) begin
            word <= word_next;
            if (byte_cnt == LAST_IN) begin
              byte_cnt         <= '0;
              state            <= S_LOAD_WR;
              o_write_inst_mem <= 1'b1;
              o_inst_mem_addr  <= addr;
              o_inst_mem_data  <= word_next;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        S_LOAD_WR: begin
          // Stop on the halt word or at the top of memory; the address never wraps.
          if (word == HALT_WORD || addr == ADDR_MAX) begin
            state <= S_IDLE;
          end else begin
            addr  <= addr + 1'b1;
            state <= S_LOAD;
          end
        end
        S_RUN: begin
          if (i_halt) begin
            state    <= S_CAPTURE;
            o_enable <= 1'b0;
          end
        end
        S_STEP: begin
          state    <= S_CAPTURE;
          o_enable <= 1'b0;
        end
        S_CAPTURE: begin
          dump       <= i_snapshot;
          tx_idx     <= '0;
          o_tx_valid <= 1'b1;
          o_tx_data  <= i_snapshot[DUMP_BITS-1 -: 8];
          state      <= S_SEND;
        end
        S_SEND: begin
          // dump is shifted so its top byte always matches o_tx_data.
          if (i_tx_ready) begin
            if (tx_idx == LAST_TX) begin
              o_tx_valid <= 1'b0;
              state      <= S_IDLE;
            end else begin
              tx_idx    <= tx_idx + 1'b1;
              o_tx_data <= dump[DUMP_BITS-9 -: 8];
              dump      <= dump << 8;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Scoreboard bench for debug_controller: load, step, run, backpressure,
// address limit and reset-mid-load scenarios.
module tb_debug_controller;

  localparam int IB = 32;
  localparam int PB = 2;
  localparam int DB = 64;
  localparam logic [31:0] HALT = 32'hFC000000;

  logic          clk;
  logic          rst;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic          o_enable;
  logic          o_write_inst_mem;
  logic [PB-1:0] o_inst_mem_addr;
  logic [IB-1:0] o_inst_mem_data;
  logic          i_halt;
  logic [DB-1:0] i_snapshot;
  logic          o_busy;
  logic [2:0]    dbg_state;

  debug_controller #(
    .INSTRUCTION_BITS(IB),
    .PC_BITS(PB),
    .DUMP_BITS(DB),
    .HALT_WORD(HALT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_enable(o_enable),
    .o_write_inst_mem(o_write_inst_mem),
    .o_inst_mem_addr(o_inst_mem_addr),
    .o_inst_mem_data(o_inst_mem_data),
    .i_halt(i_halt),
    .i_snapshot(i_snapshot),
    .o_busy(o_busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  tx_exp_q[$];
  logic [47:0] wr_exp_q[$];

  int en_cnt  = 0;
  int txv_cnt = 0;
  int wr_cnt  = 0;

  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (o_enable) en_cnt++;
      if (o_tx_valid) txv_cnt++;
      if (o_write_inst_mem) begin
        wr_cnt++;
        if (wr_exp_q.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr", {16'(o_inst_mem_addr), o_inst_mem_data}, wr_exp_q.pop_front());
      end
      if (prev_v && !prev_r) begin
        chk("hold_valid", o_tx_valid, 1);
        chk("hold_data", o_tx_data, prev_d);
      end
      if (o_tx_valid && i_tx_ready) begin
        if (tx_exp_q.size() == 0) chk("tx_unexpected", 1, 0);
        else chk("tx_byte", o_tx_data, tx_exp_q.pop_front());
      end
      prev_v = o_tx_valid;
      prev_r = i_tx_ready;
      prev_d = o_tx_data;
    end else begin
      prev_v = 1'b0;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) rx(w[8*i +: 8]);
    idle(1);
  endtask

  task automatic push_dump(input logic [DB-1:0] s);
    for (int i = DB/8 - 1; i >= 0; i--) tx_exp_q.push_back(s[8*i +: 8]);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (o_busy && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", o_busy, 0);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_write"}, o_write_inst_mem, 0);
    chk({pfx, "_addr"}, o_inst_mem_addr, 0);
    chk({pfx, "_data"}, o_inst_mem_data, 0);
    chk({pfx, "_enable"}, o_enable, 0);
    chk({pfx, "_tx_valid"}, o_tx_valid, 0);
    chk({pfx, "_tx_data"}, o_tx_data, 0);
    chk({pfx, "_busy"}, o_busy, 0);
    chk({pfx, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int e0, t0, w0;
    logic [DB-1:0] snap;
    logic [31:0]   w;
    logic [3:0]    pat;

    rst = 1'b0;
    i_rx_data = 8'h00;
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b1;
    i_halt = 1'b0;
    i_snapshot = '0;
    idle(3);
    chk_zero_outputs("reset");
    rst = 1'b1;
    idle(2);

    // load two words, ending with the halt word
    w0 = wr_cnt;
    wr_exp_q.push_back({16'd0, 32'h20080005});
    wr_exp_q.push_back({16'd1, HALT});
    rx(8'h01);
    load_word(32'h20080005);
    load_word(HALT);
    idle(2);
    chk("load_busy", o_busy, 0);
    chk("load_wr_count", wr_cnt - w0, 2);

    // single step with a snapshot change during SEND
    snap = 64'h0123456789ABCDEF;
    i_snapshot = snap;
    push_dump(snap);
    e0 = en_cnt;
    t0 = txv_cnt;
    rx(8'h03);
    chk("step_enable_on", o_enable, 1);
    idle(3);
    i_snapshot = 64'hDEADBEEFCAFEF00D;
    wait_idle(100);
    chk("step_enable_cycles", en_cnt - e0, 1);
    chk("step_tx_cycles", txv_cnt - t0, 8);

    // free run, halt after 10 enabled cycles
    snap = {$urandom, $urandom};
    i_snapshot = snap;
    push_dump(snap);
    e0 = en_cnt;
    rx(8'h02);
    idle(9);
    i_halt = 1'b1;
    idle(1);
    chk("run_enable_off", o_enable, 0);
    chk("run_tx_not_yet", o_tx_valid, 0);
    i_halt = 1'b0;
    idle(1);
    chk("run_tx_valid", o_tx_valid, 1);
    i_snapshot = ~snap;
    wait_idle(100);
    chk("run_enable_cycles", en_cnt - e0, 10);

    // backpressure: 1,0,0,1 then random ready
    snap = {$urandom, $urandom};
    i_snapshot = snap;
    push_dump(snap);
    i_tx_ready = 1'b0;
    rx(8'h03);
    idle(2);
    chk("bp_valid", o_tx_valid, 1);
    pat = 4'b1001;
    for (int k = 0; k < 80 && o_busy; k++) begin
      i_tx_ready = (k < 4) ? pat[3-k] : 1'($urandom_range(0, 1));
      idle(1);
    end
    i_tx_ready = 1'b1;
    wait_idle(50);
    chk("bp_tx_drained", tx_exp_q.size(), 0);

    // address limit: 5 non-halt words into a 4-entry memory
    w0 = wr_cnt;
    e0 = en_cnt;
    t0 = txv_cnt;
    rx(8'h01);
    for (int n = 0; n < 5; n++) begin
      for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'($urandom_range(4, 255));
      if (n < 4) wr_exp_q.push_back({16'(n), w});
      load_word(w);
    end
    idle(2);
    chk("lim_busy", o_busy, 0);
    chk("lim_wr_count", wr_cnt - w0, 4);
    chk("lim_no_enable", en_cnt - e0, 0);
    chk("lim_no_tx", txv_cnt - t0, 0);

    // reset in the middle of a word
    rx(8'h01);
    rx(8'h20);
    rx(8'h08);
    rst = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    idle(1);
    rst = 1'b1;
    idle(1);
    w0 = wr_cnt;
    wr_exp_q.push_back({16'd0, 32'hAABBCCDD});
    rx(8'h01);
    load_word(32'hAABBCCDD);
    chk("midrst_still_loading", o_busy, 1);
    wr_exp_q.push_back({16'd1, HALT});
    load_word(HALT);
    idle(2);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_wr_count", wr_cnt - w0, 2);

    chk("final_tx_q", tx_exp_q.size(), 0);
    chk("final_wr_q", wr_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_controller.md
# debug_controller

Byte-stream debug controller for the pipelined processor. Accepts commands and instruction words on a byte-serial receive port (UART side). Loads instruction memory through the datapath's instruction-memory write port, and gates the datapath enable for free-run or single-step execution. After each run or step it captures a parametrised snapshot of pipeline latches and register file and streams it out byte by byte with a valid/ready handshake.

## Interface
- INSTRUCTION_BITS, 32, instruction word width; multiple of 8
- PC_BITS, 11, instruction memory address width
- DUMP_BITS, 512, snapshot width (IF/ID, ID/EX, EX/MEM, register file concatenation); multiple of 8
- HALT_WORD, 32'hFC000000, instruction word that terminates a load
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- o_tx_data  out  8  outgoing snapshot byte
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  consumer accepts byte when high with o_tx_valid
- o_enable  out  1  datapath enable
- o_write_inst_mem  out  1  one-cycle instruction memory write strobe
- o_inst_mem_addr  out  PC_BITS  write address
- o_inst_mem_data  out  INSTRUCTION_BITS  write data
- i_halt  in  1  datapath has retired the halt instruction
- i_snapshot  in  DUMP_BITS  live pipeline/register snapshot
- o_busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, LOAD, LOAD_WR, RUN, STEP, CAPTURE, SEND.
- IDLE: rx byte 8'h01 -> LOAD, addr counter := 0, byte counter := 0; 8'h02 -> RUN; 8'h03 -> STEP; any other byte ignored.
- LOAD: each rx byte is shifted into the word register, MSB byte first. After INSTRUCTION_BITS/8 bytes -> LOAD_WR.
- LOAD_WR: one cycle with o_write_inst_mem=1, o_inst_mem_addr=addr counter, o_inst_mem_data=word.
  - If word == HALT_WORD, or addr == 2^PC_BITS-1: -> IDLE.
  - Otherwise addr += 1 and -> LOAD.
  - The halt word itself is written. Address never wraps to 0.
- RUN: o_enable=1 every cycle in state. On the rising edge where i_halt=1 -> CAPTURE. o_enable is therefore high for at least one cycle, even if i_halt is already high on entry.
- STEP: o_enable=1 for exactly one cycle, then -> CAPTURE.
- CAPTURE: o_enable=0; dump register := i_snapshot; byte index := 0; -> SEND.
- SEND: o_tx_valid=1; o_tx_data = dump byte at index, most significant byte first. On o_tx_valid & i_tx_ready, index += 1. Accepting byte DUMP_BITS/8-1 -> IDLE.
- rx bytes received outside IDLE/LOAD are dropped. The snapshot is frozen during SEND; live i_snapshot changes are ignored.
- Reset values:
  - state IDLE
  - o_enable 0, o_write_inst_mem 0, o_inst_mem_addr 0, o_inst_mem_data 0
  - o_tx_valid 0, o_tx_data 0, o_busy 0
  - all counters and dump register 0
- Reset mid-operation discards any partial word or partial dump; no write strobe is issued.

## Timing
- All outputs are registered.
- Load: o_write_inst_mem rises on the cycle after the clock edge that accepted the last byte of a word. Minimum spacing between words is one cycle; back-to-back rx strobes are legal.
- RUN/STEP: o_enable rises the cycle after the command byte is accepted.
- i_halt sampled high at edge N: o_enable low from edge N. Snapshot is sampled at edge N+1, with the datapath stalled for one cycle. o_tx_valid rises after edge N+1.
- STEP: o_enable high for exactly one clock period; snapshot sampled one cycle after enable falls.
- SEND: one byte per cycle when i_tx_ready is held high. With ready low, o_tx_data and o_tx_valid hold stable.
- o_busy is combinationally derived from the registered state.

## Test plan
- Load: rx 01, 20,08,00,05, FC,00,00,00 -> two write strobes: addr 0 data 32'h20080005, then addr 1 data 32'hFC000000. Then IDLE, o_busy=0.
- Step: DUMP_BITS=64, i_snapshot=64'h0123456789ABCDEF, rx 03 -> o_enable high exactly 1 cycle. tx bytes 01,23,45,67,89,AB,CD,EF with ready held high, 8 consecutive cycles.
- Run: rx 02, raise i_halt after 10 cycles -> o_enable high 10 cycles, low on the halt edge. Full dump follows.
- Backpressure: during SEND toggle i_tx_ready 1,0,0,1 -> o_tx_data holds the same byte while ready is low. No byte is skipped or duplicated.
- Address limit: PC_BITS=2, load 5 non-halt words -> strobes only at addr 0..3, then IDLE. The 5th word's bytes are ignored as commands.
- Reset mid-load: rx 01, 20,08, assert rst -> all outputs zero. Then rx 01 plus a 4-byte word -> write at addr 0 with only the new bytes.
